// File: rtl/water_dispenser_pkg.sv
// Shared types and default sizing for the water dispenser flow controller.
package water_dispenser_pkg;

  localparam int unsigned AMOUNT_WIDTH_DEF   = 16;
  localparam int unsigned MAX_AMOUNT_DEF     = 999;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000000;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/flow_pulse_sync.sv
// Brings the raw flow-sensor pulse into the clock domain and emits a one-cycle
// tick on each synchronised rising edge.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_pulse          raw flow-sensor input (asynchronous to i_clk)
//   o_pulse_tick_c   1-cycle tick, combinational from the synchroniser flops
module flow_pulse_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pulse,
  output logic o_pulse_tick_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two metastability flops plus one history flop for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pulse;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Tick is live during the cycle before the third edge after first sampling,
  // so the consumer registers the count on that third edge.
  assign o_pulse_tick_c = r_sync2 & ~r_prev;

endmodule

// File: rtl/water_flow_controller.sv
// Opens the valve for a confirmed amount and meters it via flow-sensor pulses,
// with user abort and dry/blocked-line timeout detection.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          1-cycle strobe with i_amount from the dispenser UI
//   i_amount         requested units (clamped to MAX_AMOUNT)
//   i_abort          cancel a run; acknowledges a fault
//   i_flow_pulse     raw flow-sensor pulse, 1 pulse = 1 unit
//   o_valve_open     valve energised
//   o_busy           run in progress
//   o_done           1-cycle strobe when a run ends (complete or aborted)
//   o_aborted        last run ended by abort, held until next start
//   o_fault          flow timeout, held until abort
//   o_remaining      units still to dispense
//   o_dispensed      units dispensed in the current/last run
module water_flow_controller
  import water_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_WIDTH   = AMOUNT_WIDTH_DEF,
  parameter int unsigned MAX_AMOUNT     = MAX_AMOUNT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [AMOUNT_WIDTH-1:0] i_amount,
  input  logic                    i_abort,
  input  logic                    i_flow_pulse,
  output logic                    o_valve_open,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_aborted,
  output logic                    o_fault,
  output logic [AMOUNT_WIDTH-1:0] o_remaining,
  output logic [AMOUNT_WIDTH-1:0] o_dispensed
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AMOUNT_WIDTH-1:0] MAX_AMT  = AMOUNT_WIDTH'(MAX_AMOUNT);
  localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]        TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [AMOUNT_WIDTH-1:0] r_remaining;
  logic [AMOUNT_WIDTH-1:0] w_remaining_nxt;
  logic [AMOUNT_WIDTH-1:0] r_dispensed;
  logic [AMOUNT_WIDTH-1:0] w_dispensed_nxt;
  logic [TMO_W-1:0]        r_tmo;
  logic [TMO_W-1:0]        w_tmo_nxt;
  logic                    r_aborted;
  logic                    w_aborted_nxt;
  logic                    r_valve_open;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_fault;
  logic                    w_tick;
  logic [AMOUNT_WIDTH-1:0] w_amount_clamped;
  logic                    w_count;

  flow_pulse_sync u_flow_sync (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pulse        (i_flow_pulse),
    .o_pulse_tick_c (w_tick)
  );

  assign w_amount_clamped = (i_amount > MAX_AMT) ? MAX_AMT : i_amount;
  // A tick only meters water while running with units left to go
  assign w_count          = (r_state == RUN) && w_tick && (r_remaining != '0);

  // Next-state, counters and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_dispensed_nxt = r_dispensed;
    w_tmo_nxt       = r_tmo;
    w_aborted_nxt   = r_aborted;

    case (r_state)
      IDLE: begin
        if (i_start && (i_amount != '0)) begin
          w_state_nxt     = RUN;
          w_remaining_nxt = w_amount_clamped;
          w_dispensed_nxt = '0;
          w_tmo_nxt       = '0;
          w_aborted_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (r_tmo != TMO_MAX) w_tmo_nxt = r_tmo + TMO_W'(1);
        if (w_count) begin
          w_remaining_nxt = r_remaining - AMOUNT_WIDTH'(1);
          w_dispensed_nxt = r_dispensed + AMOUNT_WIDTH'(1);
          w_tmo_nxt       = '0;
        end
        // Abort beats completion and timeout; a pulse beats timeout
        if (i_abort) begin
          w_state_nxt   = DONE;
          w_aborted_nxt = 1'b1;
        end else if (w_count && (r_remaining == AMOUNT_WIDTH'(1))) begin
          w_state_nxt = DONE;
        end else if (!w_count && (r_tmo >= TMO_LAST)) begin
          w_state_nxt = FAULT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      FAULT: begin
        if (i_abort) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_dispensed  <= '0;
      r_tmo        <= '0;
      r_aborted    <= 1'b0;
      r_valve_open <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_dispensed  <= w_dispensed_nxt;
      r_tmo        <= w_tmo_nxt;
      r_aborted    <= w_aborted_nxt;
      r_valve_open <= (w_state_nxt == RUN);
      r_busy       <= (w_state_nxt == RUN);
      r_done       <= (w_state_nxt == DONE);
      r_fault      <= (w_state_nxt == FAULT);
    end
  end

  assign o_valve_open = r_valve_open;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_aborted    = r_aborted;
  assign o_fault      = r_fault;
  assign o_remaining  = r_remaining;
  assign o_dispensed  = r_dispensed;

endmodule

// File: tb/tb_water_flow_controller.sv
// Self-checking bench for water_flow_controller with a unit-counting reference model.
module tb_water_flow_controller;

  localparam int unsigned AW   = 16;
  localparam int unsigned MAXA = 999;
  localparam int unsigned TMO  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] amount;
  logic          abort_req;
  logic          flow;
  logic          valve, busy, done, aborted, fault;
  logic [AW-1:0] remaining, dispensed;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: units left / units delivered / abort flag
  int m_rem  = 0;
  int m_disp = 0;
  int m_abrt = 0;

  always #5 clk = ~clk;

  water_flow_controller #(
    .AMOUNT_WIDTH   (AW),
    .MAX_AMOUNT     (MAXA),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_amount     (amount),
    .i_abort      (abort_req),
    .i_flow_pulse (flow),
    .o_valve_open (valve),
    .o_busy       (busy),
    .o_done       (done),
    .o_aborted    (aborted),
    .o_fault      (fault),
    .o_remaining  (remaining),
    .o_dispensed  (dispensed)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_start(input int amt);
    m_rem  = (amt > int'(MAXA)) ? int'(MAXA) : amt;
    m_disp = 0;
    m_abrt = 0;
  endfunction

  function automatic void model_pulse();
    if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_disp = m_disp + 1;
    end
  endfunction

  // Flow pulse high for two clocks; returns just after the counting edge
  task automatic do_pulse();
    flow = 1'b1;
    step();
    step();
    flow = 1'b0;
    step();
  endtask

  task automatic issue_start(input int amt);
    amount = AW'(amt);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort_req = 1'b0; flow = 1'b0; amount = '0;
    #23;
    n_checks++;
    if ({valve, busy, done, aborted, fault, remaining, dispensed} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v%b b%b d%b a%b f%b r%0d s%0d exp all 0",
               valve, busy, done, aborted, fault, remaining, dispensed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0 || valve !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got busy %b valve %b exp 0 0", busy, valve);
    end
  endtask

  task automatic test_normal(input int amt, input int gap);
    issue_start(amt);
    model_start(amt);
    n_checks++;
    if (valve !== 1'b1 || busy !== 1'b1 || remaining !== AW'(m_rem) || dispensed !== 16'd0) begin
      n_errors++;
      $display("FAIL normal_start: got v%b b%b r%0d s%0d exp v1 b1 r%0d s0",
               valve, busy, remaining, dispensed, m_rem);
    end
    for (int k = 1; k <= amt; k++) begin
      flow = 1'b1;
      step();
      step();
      flow = 1'b0;
      if (k == 1) begin
        n_checks++;
        if (dispensed !== 16'd0) begin
          n_errors++;
          $display("FAIL normal_latency: counted early, got %0d exp 0", dispensed);
        end
      end
      step();
      model_pulse();
      n_checks++;
      if (dispensed !== AW'(m_disp) || remaining !== AW'(m_rem)) begin
        n_errors++;
        $display("FAIL normal_count: got s%0d r%0d exp s%0d r%0d", dispensed, remaining, m_disp, m_rem);
      end
      if (m_rem > 0) begin
        n_checks++;
        if (done !== 1'b0 || valve !== 1'b1) begin
          n_errors++;
          $display("FAIL normal_running: got done %b valve %b exp 0 1", done, valve);
        end
        repeat (gap) step();
      end else begin
        n_checks++;
        if (done !== 1'b1 || valve !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0) begin
          n_errors++;
          $display("FAIL normal_end: got d%b v%b b%b a%b exp d1 v0 b0 a0", done, valve, busy, aborted);
        end
      end
    end
    step();
    n_checks++;
    if (done !== 1'b0 || dispensed !== AW'(m_disp) || remaining !== 16'd0) begin
      n_errors++;
      $display("FAIL normal_hold: got d%b s%0d r%0d exp d0 s%0d r0", done, dispensed, remaining, m_disp);
    end
  endtask

  task automatic test_abort();
    issue_start(19);
    model_start(19);
    repeat (5) begin
      do_pulse();
      model_pulse();
      repeat (3) step();
    end
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    m_abrt = 1;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || remaining !== 16'd14 || dispensed !== 16'd5 || valve !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_end: got d%b a%b r%0d s%0d v%b exp d1 a1 r14 s5 v0",
               done, aborted, remaining, dispensed, valve);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || aborted !== 1'b1 || remaining !== AW'(m_rem)) begin
      n_errors++;
      $display("FAIL abort_hold: got d%b a%b r%0d exp d0 a1 r%0d", done, aborted, remaining, m_rem);
    end
    issue_start(3);
    model_start(3);
    n_checks++;
    if (aborted !== 1'b0 || remaining !== 16'd3 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_restart: got a%b r%0d b%b exp a0 r3 b1", aborted, remaining, busy);
    end
    repeat (3) begin
      do_pulse();
      model_pulse();
    end
    n_checks++;
    if (done !== 1'b1 || dispensed !== 16'd3 || aborted !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_rerun_done: got d%b s%0d a%b exp d1 s3 a0", done, dispensed, aborted);
    end
    step();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int amt;
      int abort_after;
      int gap;
      int n;
      amt         = int'($urandom_range(1, 25));
      abort_after = int'($urandom_range(0, 30));
      gap         = int'($urandom_range(0, 9));
      n           = (abort_after < amt) ? abort_after : amt;
      issue_start(amt);
      model_start(amt);
      for (int k = 0; k < n; k++) begin
        if (k != 0) repeat (gap) step();
        do_pulse();
        model_pulse();
      end
      if (abort_after < amt) begin
        abort_req = 1'b1;
        step();
        abort_req = 1'b0;
        m_abrt = 1;
      end
      n_checks++;
      if (done !== 1'b1 || valve !== 1'b0 || aborted !== m_abrt[0] ||
          remaining !== AW'(m_rem) || dispensed !== AW'(m_disp)) begin
        n_errors++;
        $display("FAIL random_%0d: got d%b v%b a%b r%0d s%0d exp d1 v0 a%0d r%0d s%0d",
                 it, done, valve, aborted, remaining, dispensed, m_abrt, m_rem, m_disp);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    issue_start(4);
    model_start(4);
    do_pulse();
    model_pulse();
    repeat (TMO - 1) step();
    n_checks++;
    if (fault !== 1'b0 || valve !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_early: got f%b v%b exp f0 v1", fault, valve);
    end
    step();
    n_checks++;
    if (fault !== 1'b1 || valve !== 1'b0 || busy !== 1'b0 || remaining !== 16'd3 || dispensed !== 16'd1) begin
      n_errors++;
      $display("FAIL timeout_fault: got f%b v%b b%b r%0d s%0d exp f1 v0 b0 r3 s1",
               fault, valve, busy, remaining, dispensed);
    end
    issue_start(5);
    do_pulse();
    n_checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || remaining !== 16'd3 || dispensed !== 16'd1) begin
      n_errors++;
      $display("FAIL timeout_frozen: got f%b b%b r%0d s%0d exp f1 b0 r3 s1", fault, busy, remaining, dispensed);
    end
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || done !== 1'b0 || valve !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_ack: got f%b d%b v%b exp f0 d0 v0", fault, done, valve);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_nodone: got d%b b%b exp d0 b0", done, busy);
    end
  endtask

  // Pulses landing on the exact timeout edge must be counted, not faulted
  task automatic test_timeout_race();
    issue_start(2);
    model_start(2);
    repeat (TMO - 3) step();
    do_pulse();
    model_pulse();
    n_checks++;
    if (fault !== 1'b0 || busy !== 1'b1 || dispensed !== 16'd1) begin
      n_errors++;
      $display("FAIL race_mid: got f%b b%b s%0d exp f0 b1 s1", fault, busy, dispensed);
    end
    repeat (TMO - 3) step();
    do_pulse();
    model_pulse();
    n_checks++;
    if (fault !== 1'b0 || done !== 1'b1 || dispensed !== 16'd2 || remaining !== 16'd0) begin
      n_errors++;
      $display("FAIL race_final: got f%b d%b s%0d r%0d exp f0 d1 s2 r0", fault, done, dispensed, remaining);
    end
    step();
  endtask

  task automatic test_edge_cases();
    int prev_rem;
    int prev_disp;
    prev_rem  = int'(remaining);
    prev_disp = int'(dispensed);
    issue_start(0);
    step();
    n_checks++;
    if (busy !== 1'b0 || valve !== 1'b0 || done !== 1'b0 || remaining !== AW'(prev_rem)) begin
      n_errors++;
      $display("FAIL edge_zero: got b%b v%b d%b r%0d exp b0 v0 d0 r%0d", busy, valve, done, remaining, prev_rem);
    end
    do_pulse();
    step();
    n_checks++;
    if (dispensed !== AW'(prev_disp)) begin
      n_errors++;
      $display("FAIL edge_idle_pulse: got s%0d exp s%0d", dispensed, prev_disp);
    end
    issue_start(1200);
    model_start(1200);
    n_checks++;
    if (remaining !== 16'd999 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL edge_clamp: got r%0d b%b exp r999 b1", remaining, busy);
    end
    issue_start(5);
    do_pulse();
    model_pulse();
    n_checks++;
    if (remaining !== AW'(m_rem) || dispensed !== 16'd1) begin
      n_errors++;
      $display("FAIL edge_start_in_run: got r%0d s%0d exp r%0d s1", remaining, dispensed, m_rem);
    end
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || remaining !== 16'd998) begin
      n_errors++;
      $display("FAIL edge_cleanup: got d%b a%b r%0d exp d1 a1 r998", done, aborted, remaining);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    issue_start(9);
    repeat (3) begin
      do_pulse();
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valve, busy, done, aborted, fault, remaining, dispensed} !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: got v%b b%b d%b a%b f%b r%0d s%0d exp all 0",
               valve, busy, done, aborted, fault, remaining, dispensed);
    end
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    do_pulse();
    step();
    n_checks++;
    if (busy !== 1'b0 || valve !== 1'b0 || remaining !== 16'd0 || dispensed !== 16'd0) begin
      n_errors++;
      $display("FAIL midrun_idle: got b%b v%b r%0d s%0d exp b0 v0 r0 s0", busy, valve, remaining, dispensed);
    end
  endtask

  task automatic test_simultaneous();
    int amt;
    int strobes;
    amt = int'($urandom_range(1, 8));
    issue_start(amt);
    model_start(amt);
    for (int k = 1; k < amt; k++) begin
      do_pulse();
      model_pulse();
    end
    flow = 1'b1;
    step();
    step();
    flow = 1'b0;
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    model_pulse();
    m_abrt = 1;
    n_checks++;
    if (dispensed !== AW'(amt) || remaining !== 16'd0 || aborted !== 1'b1 || done !== 1'b1) begin
      n_errors++;
      $display("FAIL simul_end: got s%0d r%0d a%b d%b exp s%0d r0 a1 d1", dispensed, remaining, aborted, done, amt);
    end
    strobes = 0;
    repeat (4) begin
      step();
      if (done === 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin
      n_errors++;
      $display("FAIL simul_single_done: got %0d extra strobes exp 0", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_normal(22, 5);
    test_normal(int'($urandom_range(1, 12)), int'($urandom_range(0, 8)));
    test_abort();
    test_random();
    test_timeout();
    test_timeout_race();
    test_edge_cases();
    test_simultaneous();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
